pipeline_hazard_ctrl: RTL

- Sequences the IF/ID and ID/EX pipeline registers of the five-stage core.
- Detects load-use hazards and inserts one bubble into ID/EX while freezing PC and IF/ID.
- Flushes IF/ID and ID/EX on a taken branch or jump resolved in EX.
- Freezes the front end while a multi-cycle EX operation (mul/div) runs, with a timeout watchdog and stall performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the IF/ID and ID/EX registers of the five-stage core:
// load-use bubbles, branch flushes, and multi-cycle EX freezes with a watchdog and stall counters.
module pipeline_hazard_ctrl #(
  parameter int REG_COUNT  = 32,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(REG_COUNT)-1:0] id_rs1_addr,
  input  logic [$clog2(REG_COUNT)-1:0] id_rs2_addr,
  input  logic                         id_uses_rs1,
  input  logic                         id_uses_rs2,
  input  logic [$clog2(REG_COUNT)-1:0] ex_rd_addr,
  input  logic                         ex_mem_read,
  input  logic                         ex_branch_taken,
  input  logic                         ex_mc_start,
  input  logic                         mc_done,
  output logic                         pc_we,
  output logic                         if_id_we,
  output logic                         if_id_flush,
  output logic                         id_ex_we,
  output logic                         id_ex_bubble,
  output logic                         ex_mem_bubble,
  output logic                         mc_timeout_err,
  output logic [CNT_WIDTH-1:0]         load_stall_cnt,
  output logic [CNT_WIDTH-1:0]         mc_stall_cnt
);

  localparam int AW = $clog2(REG_COUNT);
  localparam int TW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t        state;
  logic [TW-1:0] tc;
  logic          branch;
  logic          lu;
  logic          lu_stall;
  logic          mcs;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    branch   = (state == RUN) && ex_branch_taken;
    lu       = ex_mem_read && (ex_rd_addr != '0) &&
               ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    mcs      = ((state == RUN) && ex_mc_start && !branch && !mc_done) ||
               ((state == MC_WAIT) && !mc_done);
    // Priority: frozen EX first, then branch flush, then load-use; lu only matters in RUN.
    lu_stall = (state == RUN) && lu && !mcs && !branch;
  end

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (mcs) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (branch) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu_stall) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
    // Everything is held inactive while reset is asserted.
    if (!rst_n) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_we      = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      tc             <= '0;
      mc_timeout_err <= 1'b0;
      load_stall_cnt <= '0;
      mc_stall_cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mc_start && !branch && !mc_done) begin
            state <= MC_WAIT;
            tc    <= TW'(1);
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state <= RUN;
            tc    <= '0;
          end else if (tc == TW'(MC_TIMEOUT)) begin
            state          <= RUN;
            tc             <= '0;
            mc_timeout_err <= 1'b1;
          end else begin
            tc <= tc + TW'(1);
          end
        end
        default: begin
          state <= RUN;
          tc    <= '0;
        end
      endcase
      if (lu_stall) load_stall_cnt <= sat_inc(load_stall_cnt);
      if (mcs)      mc_stall_cnt   <= sat_inc(mc_stall_cnt);
    end
  end

  logic unused_aw;
  assign unused_aw = (AW > 0);

endmodule
